hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Scoreboard-based pipeline hazard control: RAW/WAW/in-flight-limit stalls,
// serialize drain FSM and branch-redirect squash. Optional stall counter under CORE_HAZARD_STAT_EN.
module hazard_ctrl #(
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic        id_reg_wen,
  input  logic [4:0]  id_reg_waddr,
  input  logic        id_serialize,
  input  logic        ex_redirect,
  input  logic        wb_wen,
  input  logic [4:0]  wb_waddr,
  output logic        stall_if,
  output logic        stall_id,
  output logic        id_bubble,
  output logic        id_flush,
  output logic [31:0] sb_pending,
  output logic [2:0]  sb_count,
`ifdef CORE_HAZARD_STAT_EN
  output logic [31:0] stall_cnt,
`endif
  output logic        sb_err
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NREG   = 32;
  localparam int unsigned STAT_W = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic rs1_raw, rs2_raw, waw, full, hazard, drain_stall, issue;
  logic set_en, clr_en, bad_wb;

  // Hazards are evaluated on the registered pending bits only (no WB bypass)
  assign rs1_raw = id_rs1_used & (id_rs1_addr != 5'd0) & pend_q[id_rs1_addr];
  assign rs2_raw = id_rs2_used & (id_rs2_addr != 5'd0) & pend_q[id_rs2_addr];
  assign waw     = id_reg_wen & (id_reg_waddr != 5'd0) & pend_q[id_reg_waddr];
  assign full    = id_reg_wen & (id_reg_waddr != 5'd0) & (cnt_q == CNT_W'(MAX_INFLIGHT));
  assign hazard  = id_valid & (rs1_raw | rs2_raw | waw | full);

  assign drain_stall = (state_q == S_DRAIN) & (cnt_q != '0);

  assign stall_id  = (hazard | drain_stall) & ~ex_redirect;
  assign stall_if  = stall_id;
  assign id_bubble = ex_redirect | stall_id;
  assign id_flush  = ex_redirect;
  assign issue     = id_valid & ~stall_id & ~ex_redirect;

  assign set_en = issue & id_reg_wen & (id_reg_waddr != 5'd0);
  assign clr_en = wb_wen & (wb_waddr != 5'd0) & pend_q[wb_waddr];
  assign bad_wb = wb_wen & (wb_waddr != 5'd0) & ~pend_q[wb_waddr];

  // Serialize FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (id_valid & id_serialize & (cnt_q != '0) & ~ex_redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (issue | ex_redirect) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scoreboard next state; set and clear never target the same register
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = err_q | bad_wb;
    if (set_en) begin
      pend_d[id_reg_waddr] = 1'b1;
    end
    if (clr_en) begin
      pend_d[wb_waddr] = 1'b0;
    end
    pend_d[0] = 1'b0;
    case ({set_en, clr_en})
      2'b10: if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign sb_pending = pend_q;
  assign sb_count   = cnt_q;
  assign sb_err     = err_q;

`ifdef CORE_HAZARD_STAT_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of ID stall cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_wen, id_serialize;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_reg_waddr, wb_waddr;
  logic        ex_redirect, wb_wen;
  logic        stall_if, stall_id, id_bubble, id_flush, sb_err;
  logic [31:0] sb_pending;
  logic [2:0]  sb_count;
`ifdef CORE_HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.MAX_INFLIGHT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_reg_wen   (id_reg_wen),
    .id_reg_waddr (id_reg_waddr),
    .id_serialize (id_serialize),
    .ex_redirect  (ex_redirect),
    .wb_wen       (wb_wen),
    .wb_waddr     (wb_waddr),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .id_bubble    (id_bubble),
    .id_flush     (id_flush),
    .sb_pending   (sb_pending),
    .sb_count     (sb_count),
`ifdef CORE_HAZARD_STAT_EN
    .stall_cnt    (stall_cnt),
`endif
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic [2:0]  cnt;
    logic [31:0] pend;
    logic        err;
    logic        in_rst;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic ok;
      e  = q.pop_front();
      ok = (stall_id === e.stall) && (stall_if === e.stall) &&
           (id_flush === e.flush) && (id_bubble === (e.stall | e.flush)) &&
           (sb_count === e.cnt) && (sb_pending === e.pend) && (sb_err === e.err);
`ifdef CORE_HAZARD_STAT_EN
      if (e.in_rst && (stall_cnt !== 32'd0)) ok = 1'b0;
`endif
      n_vec++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s: got stall=%b/%b bub=%b flush=%b cnt=%0d pend=%h err=%b, want stall=%b bub=%b flush=%b cnt=%0d pend=%h err=%b",
                 e.name, stall_id, stall_if, id_bubble, id_flush, sb_count, sb_pending, sb_err,
                 e.stall, e.stall | e.flush, e.flush, e.cnt, e.pend, e.err);
      end
    end
  end

  task automatic clr();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_reg_wen = 0; id_serialize = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_reg_waddr = 0; ex_redirect = 0;
    wb_wen = 0; wb_waddr = 0;
  endtask

  task automatic idw(input logic [4:0] rd);
    id_valid = 1; id_reg_wen = 1; id_reg_waddr = rd;
  endtask

  task automatic idr(input logic [4:0] rs);
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = rs;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_wen = 1; wb_waddr = rd;
  endtask

  task automatic vec(input string nm, input logic s, input logic f, input int c,
                     input logic [31:0] p, input logic e);
    exp_t x;
    x.name = nm; x.stall = s; x.flush = f; x.cnt = 3'(c); x.pend = p; x.err = e;
    x.in_rst = ~rst;
    q.push_back(x);
    @(posedge clk); #1;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 0;
    @(posedge clk); #1;
    vec("reset", 0, 0, 0, 32'h0, 0);
    rst = 1;

    // RAW on x5, released the cycle after WB's register update
    idw(5);                      vec("raw_issue",     0, 0, 0, 32'h0, 0);
    idr(5);                      vec("raw_stall",     1, 0, 1, 32'h20, 0);
    idr(5); wb(5);               vec("raw_stall_wb",  1, 0, 1, 32'h20, 0);
    idr(5);                      vec("raw_release",   0, 0, 0, 32'h0, 0);

    // x0 never tracked
    idw(0);                      vec("x0_write",      0, 0, 0, 32'h0, 0);
    idr(0); id_rs2_used = 1;     vec("x0_read",       0, 0, 0, 32'h0, 0);

    // in-flight limit of 4
    idw(1);                      vec("lim_w1",        0, 0, 0, 32'h0, 0);
    idw(2);                      vec("lim_w2",        0, 0, 1, 32'h2, 0);
    idw(3);                      vec("lim_w3",        0, 0, 2, 32'h6, 0);
    idw(4);                      vec("lim_w4",        0, 0, 3, 32'hE, 0);
    idw(6);                      vec("lim_full",      1, 0, 4, 32'h1E, 0);
    idw(6); wb(1);               vec("lim_full_wb",   1, 0, 4, 32'h1E, 0);
    idw(6);                      vec("lim_issue",     0, 0, 3, 32'h1C, 0);
    wb(2);                       vec("lim_after",     0, 0, 4, 32'h5C, 0);

    // simultaneous set/clear, then WB to non-pending register
    idw(7); wb(3);               vec("sim_issue",     0, 0, 3, 32'h58, 0);
    wb(9);                       vec("sim_result",    0, 0, 3, 32'hD0, 0);
                                 vec("err_sticky",    0, 0, 3, 32'hD0, 1);

    // serialize drain with count=2 (x6,x7); rs1=x6 also holds it in the entry cycle
    wb(4);                       vec("ser_prep",      0, 0, 3, 32'hD0, 1);
    idr(6); id_serialize = 1;    vec("ser_enter",     1, 0, 2, 32'hC0, 1);
    idr(6); id_serialize = 1; wb(6); vec("ser_wb6",   1, 0, 2, 32'hC0, 1);
    idr(6); id_serialize = 1;    vec("ser_drain",     1, 0, 1, 32'h80, 1);
    idr(6); id_serialize = 1; wb(7); vec("ser_wb7",   1, 0, 1, 32'h80, 1);
    idr(6); id_serialize = 1;    vec("ser_issue",     0, 0, 0, 32'h0, 1);
    idw(8);                      vec("ser_idle_a",    0, 0, 0, 32'h0, 1);
    idw(9);                      vec("ser_idle_b",    0, 0, 1, 32'h100, 1);
                                 vec("ser_settle",    0, 0, 2, 32'h300, 1);

    // serialize drain squashed by redirect
    idw(10); idr(8); id_serialize = 1;          vec("rd_enter",   1, 0, 2, 32'h300, 1);
    idw(10); idr(8); id_serialize = 1; wb(8);   vec("rd_wb8",     1, 0, 2, 32'h300, 1);
    idw(10); idr(8); id_serialize = 1;          vec("rd_drain",   1, 0, 1, 32'h200, 1);
    idw(10); idr(8); id_serialize = 1; ex_redirect = 1; vec("rd_redirect", 0, 1, 1, 32'h200, 1);
                                 vec("rd_no_pend",    0, 0, 1, 32'h200, 1);
    idw(11);                     vec("rd_idle",       0, 0, 1, 32'h200, 1);
                                 vec("rd_settle",     0, 0, 2, 32'hA00, 1);

    // redirect overrides RAW and squashes the write
    idr(11); idw(12); ex_redirect = 1;          vec("redir_prio", 0, 1, 2, 32'hA00, 1);
                                 vec("redir_nopend",  0, 0, 2, 32'hA00, 1);

    // async reset mid-cycle with count=3
    idw(13);                     vec("ar_w13",        0, 0, 2, 32'hA00, 1);
                                 vec("ar_pre",        0, 0, 3, 32'h2A00, 1);
    idr(11);                     vec("ar_stall",      1, 0, 3, 32'h2A00, 1);
    #2 rst = 0;
    #1;
                                 vec("ar_cleared",    0, 0, 0, 32'h0, 0);
    rst = 1;
    idw(1);                      vec("ar_resume",     0, 0, 0, 32'h0, 0);
                                 vec("ar_resume2",    0, 0, 1, 32'h2, 0);

    @(posedge clk); #1;
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL queue_drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
